mux8_32: RTL and testbench

Byte-to-word packer on the receive side of the lane: collects four consecutive valid bytes arriving at the byte rate (clk_4f) and presents them as one 32-bit word on lane_0 with a one-cycle valid_0 strobe. It is the inverse of the 32-to-8 demux on the transmit side, so the byte stream produced by that demux passes back through this block and reappears as the original 32-bit words. It runs entirely in the clk_4f domain; any clk_f consumer samples the held lane_0.

---
 rtl/mux_pkg.sv | 7 +
 rtl/mux8_32_shifter.sv | 16 +
 rtl/mux8_32.sv | 46 ++++
 tb/tb_mux8_32.sv | 135 +++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// mux_pkg: shared state encoding and widths for the mux8_32 byte-to-word packer
package mux_pkg;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;
  typedef enum logic [1:0] {IDLE, B1, B2, B3} state_t;
endpackage

// File: rtl/mux8_32_shifter.sv
// byte_shifter8_32: holds up to three bytes and presents them with the current byte as a full word
module byte_shifter8_32
  import mux_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [BYTE_W-1:0] d,
  output logic [WORD_W-1:0] word
);
  logic [WORD_W-BYTE_W-1:0] held;
  always_ff @(posedge clk)
    held <= (rst || clr) ? '0 : load ? word[WORD_W-BYTE_W-1:0] : held;
  assign word = {held, d};
endmodule

// File: rtl/mux8_32.sv
// mux8_32: packs four valid bytes into one 32-bit word with valid_0/frag strobes (option: MUX8_32_PARTIAL_FLUSH_EN)
module mux8_32
  import mux_pkg::*;
(
  input  logic              clk_4f,
  input  logic              reset,
  input  logic [BYTE_W-1:0] data_in,
  input  logic              valid_in,
  output logic [WORD_W-1:0] lane_0,
  output logic              valid_0,
  output logic              frag
);
  state_t state, state_nxt;
  logic [WORD_W-1:0] word, lane_nxt;
  logic done, gap, valid_nxt;
  assign done = state == B3 && valid_in;
  assign gap = state != IDLE && !valid_in;
  byte_shifter8_32 u_shift (
    .clk (clk_4f),
    .rst (reset),
    .clr (gap),
    .load(valid_in),
    .d   (data_in),
    .word(word)
  );
  always_ff @(posedge clk_4f)
    state <= reset ? IDLE : state_nxt;
  always_comb
    state_nxt = (!valid_in || state == B3) ? IDLE : state_t'(state + 1'b1);
`ifdef MUX8_32_PARTIAL_FLUSH_EN
  always_comb begin
    lane_nxt = done ? word : gap ? {word[WORD_W-1:BYTE_W], {BYTE_W{1'b0}}} << {~state, 3'b000} : lane_0;
    valid_nxt = done || gap;
  end
`else
  always_comb begin
    lane_nxt = done ? word : lane_0;
    valid_nxt = done;
  end
`endif
  always_ff @(posedge clk_4f) begin
    lane_0 <= reset ? '0 : lane_nxt;
    valid_0 <= !reset && valid_nxt;
    frag <= !reset && gap;
  end
endmodule

// File: tb/tb_mux8_32.sv
// tb_mux8_32: table-driven vectors plus a round-trip scoreboard for mux8_32
module tb_mux8_32;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic valid_in = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [31:0] lane_0;
  logic valid_0, frag;
  int checks = 0;
  int failures = 0;
  logic [31:0] sb[$];

  mux8_32 dut (
    .clk_4f  (clk),
    .reset   (reset),
    .data_in (data_in),
    .valid_in(valid_in),
    .lane_0  (lane_0),
    .valid_0 (valid_0),
    .frag    (frag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic r;
    logic v;
    logic [7:0] d;
    logic ev;
    logic ef;
    logic [31:0] el;
  } vec_t;
  vec_t tv[$];

`ifdef MUX8_32_PARTIAL_FLUSH_EN
  localparam logic GV = 1'b1;
  localparam logic [31:0] G1 = 32'h11220000;
  localparam logic [31:0] G2 = 32'h5A000000;
  localparam logic [31:0] G3 = 32'h01020300;
`else
  localparam logic GV = 1'b0;
  localparam logic [31:0] G1 = 32'h05060708;
  localparam logic [31:0] G2 = 32'hA1B2C3D4;
  localparam logic [31:0] G3 = 32'hA1B2C3D4;
`endif

  task automatic add(input logic r, input logic v, input logic [7:0] d, input logic ev, input logic ef, input logic [31:0] el);
    vec_t t;
    t.r = r; t.v = v; t.d = d; t.ev = ev; t.ef = ef; t.el = el;
    tv.push_back(t);
  endtask

  task automatic drive(input logic r, input logic v, input logic [7:0] d);
    reset = r;
    valid_in = v;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got {valid,frag,lane}=%h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [31:0] words[4];
    logic [31:0] w, e;
    for (int i = 0; i < 3; i++) add(1, 1, 8'hFF, 0, 0, 32'h0);
    add(0, 1, 8'hAA, 0, 0, 32'h0);
    add(0, 1, 8'hBB, 0, 0, 32'h0);
    add(0, 1, 8'hCC, 0, 0, 32'h0);
    add(0, 1, 8'hDD, 1, 0, 32'hAABBCCDD);
    add(0, 0, 8'h00, 0, 0, 32'hAABBCCDD);
    add(0, 0, 8'h5C, 0, 0, 32'hAABBCCDD);
    for (int i = 1; i <= 8; i++)
      add(0, 1, 8'(i), i == 4 || i == 8, 0, i < 4 ? 32'hAABBCCDD : i < 8 ? 32'h01020304 : 32'h05060708);
    add(0, 0, 8'h00, 0, 0, 32'h05060708);
    add(0, 1, 8'h11, 0, 0, 32'h05060708);
    add(0, 1, 8'h22, 0, 0, 32'h05060708);
    add(0, 0, 8'h99, GV, 1, G1);
    add(0, 1, 8'hA1, 0, 0, G1);
    add(0, 1, 8'hB2, 0, 0, G1);
    add(0, 1, 8'hC3, 0, 0, G1);
    add(0, 1, 8'hD4, 1, 0, 32'hA1B2C3D4);
    add(0, 1, 8'h5A, 0, 0, 32'hA1B2C3D4);
    add(0, 0, 8'h77, GV, 1, G2);
    add(0, 0, 8'h00, 0, 0, G2);
    add(0, 1, 8'h01, 0, 0, G2);
    add(0, 1, 8'h02, 0, 0, G2);
    add(0, 1, 8'h03, 0, 0, G2);
    add(0, 0, 8'h04, GV, 1, G3);
    add(0, 1, 8'h11, 0, 0, G3);
    add(0, 1, 8'h22, 0, 0, G3);
    add(0, 1, 8'h33, 0, 0, G3);
    add(1, 1, 8'hEE, 0, 0, 32'h0);
    add(0, 1, 8'h44, 0, 0, 32'h0);
    add(0, 1, 8'h55, 0, 0, 32'h0);
    add(0, 1, 8'h66, 0, 0, 32'h0);
    add(0, 1, 8'h77, 1, 0, 32'h44556677);
    add(0, 0, 8'h00, 0, 0, 32'h44556677);
    foreach (tv[i]) begin
      drive(tv[i].r, tv[i].v, tv[i].d);
      check($sformatf("vec%0d", i), {valid_0, frag, lane_0}, {tv[i].ev, tv[i].ef, tv[i].el});
    end
    words[0] = 32'hDEADBEEF;
    words[1] = 32'h12345678;
    words[2] = $urandom;
    words[3] = $urandom;
    foreach (words[k]) begin
      w = words[k];
      sb.push_back(w);
      for (int b = 0; b < 4; b++) begin
        drive(0, 1, w[31-8*b -: 8]);
        check("rt_frag", {1'b0, frag, 32'h0}, 34'h0);
        if (valid_0) begin
          if (sb.size() == 0) begin
            check("rt_unexpected", {valid_0, 1'b0, lane_0}, 34'h0);
          end else begin
            e = sb.pop_front();
            check("rt_word", {1'b1, 1'b0, lane_0}, {1'b1, 1'b0, e});
          end
        end
      end
    end
    check("rt_drain", {2'b00, 32'(sb.size())}, 34'h0);
    drive(0, 0, 8'h00);
    check("rt_idle", {valid_0, frag, lane_0}, {2'b00, words[3]});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
